// File: rtl/store_merge_unit.sv
// Sub-word store path: sb/sh use read-modify-write on word memory, sw writes directly.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   req, store_type       - store request (sampled in IDLE) and size (00 b, 01 h, 1x w)
//   addr, wdata           - byte address and store data (lane taken from low bits)
//   busy, done            - non-IDLE indicator, completion pulse
//   addr_err, bus_err     - misalignment pulse, memory timeout pulse
//   mem_addr, mem_rd/wr   - word-aligned memory address and strobes
//   mem_wdata, mem_rdata  - merged write word, read data
//   mem_ready             - memory acknowledge for current strobe
module store_merge_unit #(
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned CNT_W    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [1:0]  store_type,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        addr_err,
   output logic        bus_err,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        addr_q, addr_d;
   logic [1:0]         off_q, off_d;
   logic [15:0]        wdata_q, wdata_d;
   logic               byte_q, byte_d;
   logic [31:0]        merged_q, merged_d;
   logic               busy_q, done_q, addr_err_q, bus_err_q, rd_q, wr_q;
   logic               done_d, addr_err_d, bus_err_d;
   logic [31:0]        merge_c;
   logic               misalign_c;

   // Insert the latched lane into the read word, big-endian lane order.
   always_comb begin
      merge_c = mem_rdata;
      if (byte_q) begin
         case (off_q)
            2'd0:    merge_c[31:24] = wdata_q[7:0];
            2'd1:    merge_c[23:16] = wdata_q[7:0];
            2'd2:    merge_c[15:8]  = wdata_q[7:0];
            default: merge_c[7:0]   = wdata_q[7:0];
         endcase
      end else if (off_q[1]) begin
         merge_c[15:0] = wdata_q;
      end else begin
         merge_c[31:16] = wdata_q;
      end
   end

   // Halfword needs addr[0]=0; word (and reserved) needs addr[1:0]=0.
   always_comb begin
      case (store_type)
         2'b00:   misalign_c = 1'b0;
         2'b01:   misalign_c = addr[0];
         default: misalign_c = (addr[1:0] != 2'b00);
      endcase
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      off_d      = off_q;
      wdata_d    = wdata_q;
      byte_d     = byte_q;
      merged_d   = merged_q;
      done_d     = 1'b0;
      addr_err_d = 1'b0;
      bus_err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (req) begin
               addr_d  = {addr[31:2], 2'b00};
               off_d   = addr[1:0];
               wdata_d = wdata[15:0];
               byte_d  = (store_type == 2'b00);
               if (misalign_c) begin
                  state_d    = ERR;
                  addr_err_d = 1'b1;
               end else if (store_type[1] == 1'b0) begin
                  state_d = READ;
               end else begin
                  state_d  = WRITE;
                  merged_d = wdata;
               end
            end
         end
         READ: begin
            if (mem_ready) begin
               merged_d = merge_c;
               cnt_d    = '0;
               state_d  = WRITE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == CNT_W'(MAX_WAIT)) begin
                  state_d   = ERR;
                  bus_err_d = 1'b1;
               end
            end
         end
         WRITE: begin
            if (mem_ready) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == CNT_W'(MAX_WAIT)) begin
                  state_d   = ERR;
                  bus_err_d = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         off_q      <= '0;
         wdata_q    <= '0;
         byte_q     <= 1'b0;
         merged_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         addr_err_q <= 1'b0;
         bus_err_q  <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         off_q      <= off_d;
         wdata_q    <= wdata_d;
         byte_q     <= byte_d;
         merged_q   <= merged_d;
         busy_q     <= (state_d != IDLE);
         done_q     <= done_d;
         addr_err_q <= addr_err_d;
         bus_err_q  <= bus_err_d;
         rd_q       <= (state_d == READ);
         wr_q       <= (state_d == WRITE);
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign addr_err  = addr_err_q;
   assign bus_err   = bus_err_q;
   assign mem_addr  = addr_q;
   assign mem_rd    = rd_q;
   assign mem_wr    = wr_q;
   assign mem_wdata = merged_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: lane merging, latency, errors, timeout, reset.
module tb_store_merge_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic [1:0]  store_type;
   logic [31:0] addr, wdata;
   logic        busy, done, addr_err, bus_err;
   logic [31:0] mem_addr;
   logic        mem_rd, mem_wr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_ready;

   int checks = 0;
   int errors = 0;

   store_merge_unit #(.MAX_WAIT(15), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .req(req), .store_type(store_type),
      .addr(addr), .wdata(wdata), .busy(busy), .done(done),
      .addr_err(addr_err), .bus_err(bus_err), .mem_addr(mem_addr),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle; the following period is the next "cycle".
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sub-word store with immediate acknowledge: rd in c1, wr in c2, done in c3.
   task automatic sub_store(input logic [1:0] st, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input logic [31:0] exp_w);
      logic [31:0] exp_a;
      exp_a = {a[31:2], 2'b00};
      store_type = st; addr = a; wdata = wd; mem_rdata = rd; mem_ready = 1'b1; req = 1'b1;
      tick(); req = 1'b0;
      check("sub_rd_c1",   32'(mem_rd), 32'd1);
      check("sub_wr_c1",   32'(mem_wr), 32'd0);
      check("sub_addr_c1", mem_addr, exp_a);
      tick();
      check("sub_wr_c2",   32'(mem_wr), 32'd1);
      check("sub_rd_c2",   32'(mem_rd), 32'd0);
      check("sub_wdata_c2", mem_wdata, exp_w);
      tick();
      check("sub_done_c3", 32'(done), 32'd1);
      check("sub_busy_c3", 32'(busy), 32'd1);
      check("sub_wr_c3",   32'(mem_wr), 32'd0);
      tick();
      check("sub_busy_c4", 32'(busy), 32'd0);
      check("sub_done_c4", 32'(done), 32'd0);
   endtask

   // Memory never acknowledges: count strobe cycles and pulses over a fixed window.
   task automatic timeout_run(input logic [1:0] st, input logic [31:0] a,
                              input int exp_rd, input int exp_wr);
      int n_rd, n_wr, n_done, n_bus, bus_cyc;
      n_rd = 0; n_wr = 0; n_done = 0; n_bus = 0; bus_cyc = 0;
      store_type = st; addr = a; wdata = 32'h0000_00CC; mem_ready = 1'b0; req = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick(); req = 1'b0;
         if (mem_rd) n_rd++;
         if (mem_wr) n_wr++;
         if (done) n_done++;
         if (bus_err) begin n_bus++; bus_cyc = c; end
         if (mem_rd && mem_wr) check("to_rd_wr_overlap", 32'd1, 32'd0);
      end
      check("to_rd_cycles",  32'(n_rd), 32'(exp_rd));
      check("to_wr_cycles",  32'(n_wr), 32'(exp_wr));
      check("to_done_count", 32'(n_done), 32'd0);
      check("to_bus_count",  32'(n_bus), 32'd1);
      check("to_bus_cycle",  32'(bus_cyc), 32'd16);
      check("to_busy_end",   32'(busy), 32'd0);
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; store_type = 2'b00; addr = '0; wdata = '0;
      mem_rdata = '0; mem_ready = 1'b0;
      tick(); tick();
      check("rst_busy",   32'(busy), 32'd0);
      check("rst_done",   32'(done), 32'd0);
      check("rst_errs",   32'({addr_err, bus_err}), 32'd0);
      check("rst_strobe", 32'({mem_rd, mem_wr}), 32'd0);
      check("rst_addr",   mem_addr, 32'd0);
      check("rst_wdata",  mem_wdata, 32'd0);
      reset = 1'b0;
      tick();

      // Byte lanes and halfword lanes.
      sub_store(2'b00, 32'h0000_0011, 32'h0000_00AB, 32'h1122_3344, 32'h11AB_3344);
      sub_store(2'b00, 32'h0000_0000, 32'h0000_00AB, 32'h1122_3344, 32'hAB22_3344);
      sub_store(2'b00, 32'h0000_0013, 32'hFFFF_FF5A, 32'h1122_3344, 32'h1122_335A);
      sub_store(2'b01, 32'h0000_0022, 32'h0000_BEEF, 32'h1122_3344, 32'h1122_BEEF);
      sub_store(2'b01, 32'h0000_0020, 32'h0000_BEEF, 32'h1122_3344, 32'hBEEF_3344);

      // Word store with three cycles of wait.
      store_type = 2'b10; addr = 32'h0000_0040; wdata = 32'hDEAD_BEEF;
      mem_rdata = 32'h1234_5678; mem_ready = 1'b0; req = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick(); req = 1'b0;
         check("w_wr",    32'(mem_wr), 32'd1);
         check("w_rd",    32'(mem_rd), 32'd0);
         check("w_wdata", mem_wdata, 32'hDEAD_BEEF);
         check("w_addr",  mem_addr, 32'h0000_0040);
         check("w_done",  32'(done), 32'd0);
         mem_ready = (c == 4);
      end
      tick();
      check("w_done_c5", 32'(done), 32'd1);
      check("w_wr_c5",   32'(mem_wr), 32'd0);
      tick();
      check("w_busy_c6", 32'(busy), 32'd0);

      // Reserved type behaves as word; a req during DONE is dropped.
      store_type = 2'b11; addr = 32'h0000_0084; wdata = 32'hCAFE_F00D; mem_ready = 1'b1; req = 1'b1;
      tick(); req = 1'b0;
      check("r_wr_c1",    32'(mem_wr), 32'd1);
      check("r_rd_c1",    32'(mem_rd), 32'd0);
      check("r_wdata_c1", mem_wdata, 32'hCAFE_F00D);
      store_type = 2'b10; addr = 32'h0000_0080; wdata = 32'h0; req = 1'b0;
      tick();
      check("r_done_c2", 32'(done), 32'd1);
      req = 1'b1;
      tick(); req = 1'b0;
      check("r_busy_c3", 32'(busy), 32'd0);
      check("r_wr_c3",   32'(mem_wr), 32'd0);

      // Misaligned halfword and word.
      store_type = 2'b01; addr = 32'h0000_0021; req = 1'b1;
      tick(); req = 1'b0;
      check("ma_h_err_c1",  32'(addr_err), 32'd1);
      check("ma_h_bus_c1",  32'(bus_err), 32'd0);
      check("ma_h_strb_c1", 32'({mem_rd, mem_wr}), 32'd0);
      check("ma_h_busy_c1", 32'(busy), 32'd1);
      tick();
      check("ma_h_err_c2",  32'(addr_err), 32'd0);
      check("ma_h_busy_c2", 32'(busy), 32'd0);
      check("ma_h_strb_c2", 32'({mem_rd, mem_wr}), 32'd0);
      store_type = 2'b10; addr = 32'h0000_0042; req = 1'b1;
      tick(); req = 1'b0;
      check("ma_w_err_c1",  32'(addr_err), 32'd1);
      check("ma_w_strb_c1", 32'({mem_rd, mem_wr}), 32'd0);
      tick();

      // Timeouts in READ and in WRITE.
      timeout_run(2'b00, 32'h0000_0005, 15, 0);
      timeout_run(2'b10, 32'h0000_0008, 0, 15);

      // Reset mid-READ, then a normal store.
      store_type = 2'b00; addr = 32'h0000_0001; wdata = 32'h77; mem_ready = 1'b0; req = 1'b1;
      tick(); req = 1'b0;
      check("rm_rd_c1", 32'(mem_rd), 32'd1);
      tick();
      check("rm_rd_c2", 32'(mem_rd), 32'd1);
      reset = 1'b1;
      tick();
      check("rm_rd_c3",   32'(mem_rd), 32'd0);
      check("rm_busy_c3", 32'(busy), 32'd0);
      check("rm_done_c3", 32'(done), 32'd0);
      reset = 1'b0; mem_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("rm_quiet", 32'({done, busy, mem_rd, mem_wr, bus_err}), 32'd0);
      end
      sub_store(2'b00, 32'h0000_0003, 32'h0000_0055, 32'h1122_3344, 32'h1122_3355);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
